// File: rtl/ofdm_tx_pkg.sv
// Shared constants and read FSM encoding for the OFDM transmit datapath.
package ofdm_tx_pkg;

  localparam int unsigned DATA_W = 8;   // I/Q width: sign, 1 integer, DATA_W-2 fraction
  localparam int unsigned N_FFT  = 64;  // samples per symbol body
  localparam int unsigned N_CP   = 16;  // cyclic prefix length, must be < N_FFT

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StCp   = 2'd1,
    StBody = 2'd2
  } cpState_e;

endpackage

// File: rtl/cp_dual_bank_ram.sv
// Two-bank simple dual-port sample RAM, one write port and one registered read port.
// Contents are not reset; the consumer qualifies read data with its own valid.
module cp_dual_bank_ram #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned N_FFT  = 64
) (
  input  logic                     Clk,
  input  logic                     WrEn,
  input  logic                     WrBank,
  input  logic [$clog2(N_FFT)-1:0] WrIdx,
  input  logic [2*DATA_W-1:0]      WrData,
  input  logic                     RdEn,
  input  logic                     RdBank,
  input  logic [$clog2(N_FFT)-1:0] RdIdx,
  output logic [2*DATA_W-1:0]      RdData
);

  logic [2*DATA_W-1:0] mem [2][N_FFT];

  // Write port and registered read port on the same clock.
  always_ff @(posedge Clk) begin
    if (WrEn) begin
      mem[WrBank][WrIdx] <= WrData;
    end
    if (RdEn) begin
      RdData <= mem[RdBank][RdIdx];
    end
  end

endmodule

// File: rtl/cyclic_prefix_inserter.sv
// Cyclic prefix inserter: ping-pongs IFFT output symbols through two RAM banks and
// replays the last N_CP samples of each symbol ahead of its full body.
// Optional feature: define CP_SYMBOL_CNT_EN to add the 16-bit SymbolCount output.
module cyclic_prefix_inserter #(
  parameter int unsigned DATA_W = ofdm_tx_pkg::DATA_W,
  parameter int unsigned N_FFT  = ofdm_tx_pkg::N_FFT,
  parameter int unsigned N_CP   = ofdm_tx_pkg::N_CP
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic              InputEnable,
  input  logic [DATA_W-1:0] DataInRe,
  input  logic [DATA_W-1:0] DataInIm,
  output logic              InputReady,
  output logic              OutputEnable,
  output logic [DATA_W-1:0] DataOutRe,
  output logic [DATA_W-1:0] DataOutIm,
  output logic              SymbolStart
`ifdef CP_SYMBOL_CNT_EN
  ,
  output logic [15:0]       SymbolCount
`endif
);

  import ofdm_tx_pkg::*;

  localparam int unsigned IDX_W = $clog2(N_FFT);
  localparam logic [IDX_W-1:0] LastIdx    = IDX_W'(N_FFT - 1);
  localparam logic [IDX_W-1:0] CpFirstIdx = IDX_W'(N_FFT - N_CP);

  logic [1:0]       fullQ, fullD;
  logic [IDX_W-1:0] wrIdxQ, wrIdxD;
  logic             wrBankQ, wrBankD;
  logic [IDX_W-1:0] rdIdxQ, rdIdxD;
  logic             rdBankQ, rdBankD;
  cpState_e         stateQ, stateD;
  logic             outValidQ, startQ;
  logic             accept, readEn, readDone;
  logic [2*DATA_W-1:0] rdData;

  assign InputReady = ~fullQ[wrBankQ];
  assign accept     = InputEnable & InputReady;

  // Write pointer and bank-full flags; a bank fill and a bank release may coincide
  // because they always address different banks.
  always_comb begin
    fullD   = fullQ;
    wrIdxD  = wrIdxQ;
    wrBankD = wrBankQ;
    if (accept) begin
      if (wrIdxQ == LastIdx) begin
        fullD[wrBankQ] = 1'b1;
        wrIdxD         = '0;
        wrBankD        = ~wrBankQ;
      end else begin
        wrIdxD = wrIdxQ + 1'b1;
      end
    end
    if (readDone) begin
      fullD[rdBankQ] = 1'b0;
    end
  end

  // Read FSM: prefix tail first, then the whole body, chaining banks without a gap.
  always_comb begin
    stateD   = stateQ;
    rdIdxD   = rdIdxQ;
    rdBankD  = rdBankQ;
    readEn   = 1'b0;
    readDone = 1'b0;
    unique case (stateQ)
      StIdle: begin
        if (fullQ[rdBankQ]) begin
          stateD = StCp;
          rdIdxD = CpFirstIdx;
        end
      end
      StCp: begin
        readEn = 1'b1;
        if (rdIdxQ == LastIdx) begin
          stateD = StBody;
          rdIdxD = '0;
        end else begin
          rdIdxD = rdIdxQ + 1'b1;
        end
      end
      StBody: begin
        readEn = 1'b1;
        if (rdIdxQ == LastIdx) begin
          readDone = 1'b1;
          rdBankD  = ~rdBankQ;
          if (fullQ[~rdBankQ]) begin
            stateD = StCp;
            rdIdxD = CpFirstIdx;
          end else begin
            stateD = StIdle;
            rdIdxD = '0;
          end
        end else begin
          rdIdxD = rdIdxQ + 1'b1;
        end
      end
      default: stateD = StIdle;
    endcase
  end

  // Control state registers.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      fullQ   <= '0;
      wrIdxQ  <= '0;
      wrBankQ <= 1'b0;
      rdIdxQ  <= '0;
      rdBankQ <= 1'b0;
      stateQ  <= StIdle;
    end else begin
      fullQ   <= fullD;
      wrIdxQ  <= wrIdxD;
      wrBankQ <= wrBankD;
      rdIdxQ  <= rdIdxD;
      rdBankQ <= rdBankD;
      stateQ  <= stateD;
    end
  end

  // Output qualifiers aligned with the RAM's registered read data.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      outValidQ <= 1'b0;
      startQ    <= 1'b0;
    end else begin
      outValidQ <= readEn;
      startQ    <= (stateQ == StCp) && (rdIdxQ == CpFirstIdx);
    end
  end

  cp_dual_bank_ram #(
    .DATA_W (DATA_W),
    .N_FFT  (N_FFT)
  ) uRam (
    .Clk    (Clk),
    .WrEn   (accept),
    .WrBank (wrBankQ),
    .WrIdx  (wrIdxQ),
    .WrData ({DataInRe, DataInIm}),
    .RdEn   (readEn),
    .RdBank (rdBankQ),
    .RdIdx  (rdIdxQ),
    .RdData (rdData)
  );

  // Gate RAM data so idle cycles present zeros regardless of stale RAM output.
  assign OutputEnable = outValidQ;
  assign SymbolStart  = outValidQ & startQ;
  assign DataOutRe    = outValidQ ? rdData[2*DATA_W-1:DATA_W] : '0;
  assign DataOutIm    = outValidQ ? rdData[DATA_W-1:0] : '0;

`ifdef CP_SYMBOL_CNT_EN
  logic [15:0] symCntQ;

  // Symbol counter, wraps naturally from 65535 to 0.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      symCntQ <= '0;
    end else if (SymbolStart) begin
      symCntQ <= symCntQ + 16'd1;
    end
  end

  assign SymbolCount = symCntQ;
`endif

endmodule

// File: tb/tb_cyclic_prefix_inserter.sv
// Self-checking bench for cyclic_prefix_inserter (default parameters).
module tb_cyclic_prefix_inserter;

  localparam int DW = 8;
  localparam int NF = 64;
  localparam int NC = 16;

  logic          Clk = 1'b0;
  logic          Rst_n;
  logic          InputEnable;
  logic [DW-1:0] DataInRe, DataInIm;
  logic          InputReady, OutputEnable, SymbolStart;
  logic [DW-1:0] DataOutRe, DataOutIm;
`ifdef CP_SYMBOL_CNT_EN
  logic [15:0]   SymbolCount;
`endif

  cyclic_prefix_inserter dut (
    .Clk          (Clk),
    .Rst_n        (Rst_n),
    .InputEnable  (InputEnable),
    .DataInRe     (DataInRe),
    .DataInIm     (DataInIm),
    .InputReady   (InputReady),
    .OutputEnable (OutputEnable),
    .DataOutRe    (DataOutRe),
    .DataOutIm    (DataOutIm),
    .SymbolStart  (SymbolStart)
`ifdef CP_SYMBOL_CNT_EN
    ,
    .SymbolCount  (SymbolCount)
`endif
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic [DW-1:0] re;
    logic [DW-1:0] im;
    logic          start;
  } samp_t;

  typedef struct {
    string name;
    int    nSym;
    int    gap;      // idle cycles between samples, -1 = random 0..3
    bit    rnd;      // random sample data instead of ramp
    int    expOut;
    int    expStarts;
    bit    contig;
    int    expLat;
  } scen_t;

  samp_t expQ[$];
  samp_t pendQ[$];
  samp_t monE;
  int    checks = 0;
  int    errors = 0;
  int    cyc = 0;
  int    symEndCyc = 0;
  // Owned by the monitor.
  int    outCnt = 0, startCnt = 0, riseCnt = 0, riseCyc = 0;
  bit    prevOe = 1'b0;
  int    cntModel = 0;

  function automatic void check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endfunction

  // Reference: every NF accepted samples form a symbol, emitted as tail NC then all NF.
  function automatic void model_accept(input logic [DW-1:0] re, input logic [DW-1:0] im);
    samp_t s;
    s.re = re;
    s.im = im;
    s.start = 1'b0;
    pendQ.push_back(s);
    if (pendQ.size() == NF) begin
      for (int j = NF - NC; j < NF; j++) begin
        s = pendQ[j];
        s.start = (j == NF - NC);
        expQ.push_back(s);
      end
      for (int j = 0; j < NF; j++) begin
        s = pendQ[j];
        s.start = 1'b0;
        expQ.push_back(s);
      end
      pendQ.delete();
    end
  endfunction

  always @(posedge Clk) cyc <= cyc + 1;

  // Output monitor: compares every output cycle against the model stream.
  always @(negedge Clk) begin
    if (!Rst_n) begin
      prevOe = 1'b0;
      cntModel = 0;
    end else begin
`ifdef CP_SYMBOL_CNT_EN
      check("symbol_count", SymbolCount, cntModel);
`endif
      if (OutputEnable) begin
        if (expQ.size() == 0) begin
          check("unexpected_output", 1, 0);
        end else begin
          monE = expQ.pop_front();
          check("data_re", DataOutRe, monE.re);
          check("data_im", DataOutIm, monE.im);
          check("symbol_start", SymbolStart, monE.start);
        end
        if (!prevOe) begin
          riseCnt++;
          riseCyc = cyc;
        end
        outCnt++;
        if (SymbolStart) begin
          startCnt++;
          cntModel = (cntModel + 1) % 65536;
        end
      end else begin
        check("idle_zero", {DataOutRe, DataOutIm, SymbolStart}, 0);
      end
      prevOe = OutputEnable;
    end
  end

  task automatic send(input int nSamp, input int gap, input bit rnd);
    logic [DW-1:0] re, im;
    int tries, g;
    for (int i = 0; i < nSamp; i++) begin
      re = rnd ? DW'($urandom) : DW'(i);
      im = rnd ? DW'($urandom) : DW'(63 - (i % 64));
      @(negedge Clk);
      InputEnable = 1'b1;
      DataInRe = re;
      DataInIm = im;
      tries = 0;
      while (!InputReady && tries < 1000) begin
        @(negedge Clk);
        tries++;
      end
      if (tries >= 1000) begin
        check("input_ready_timeout", 0, 1);
        InputEnable = 1'b0;
        return;
      end
      model_accept(re, im);
      if (i == NF - 1) symEndCyc = cyc + 1;
      g = (gap < 0) ? int'($urandom_range(0, 3)) : gap;
      if (g > 0) begin
        @(negedge Clk);
        InputEnable = 1'b0;
        repeat (g - 1) @(negedge Clk);
      end
    end
    @(negedge Clk);
    InputEnable = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while (expQ.size() != 0 && t < 3000) begin
      @(negedge Clk);
      t++;
    end
    check("drain_timeout", expQ.size(), 0);
    repeat (4) @(negedge Clk);
  endtask

  scen_t tbl[4];
  int    outBase, startBase, riseBase, acc;
  bit    sawLow, needNew;
  logic [DW-1:0] bpRe, bpIm;

  initial begin
    tbl[0] = '{"ramp",   1,  0, 1'b0,  80, 1, 1'b1, 2};
    tbl[1] = '{"stream", 3,  0, 1'b0, 240, 3, 1'b1, 2};
    tbl[2] = '{"gapped", 1,  2, 1'b0,  80, 1, 1'b1, 2};
    tbl[3] = '{"random", 2, -1, 1'b1, 160, 2, 1'b0, 2};

    Rst_n = 1'b0;
    InputEnable = 1'b0;
    DataInRe = '0;
    DataInIm = '0;
    repeat (3) @(negedge Clk);
    check("reset_oe", OutputEnable, 0);
    check("reset_start", SymbolStart, 0);
    check("reset_data", {DataOutRe, DataOutIm}, 0);
    check("reset_ready", InputReady, 1);
    Rst_n = 1'b1;

    for (int s = 0; s < 4; s++) begin
      outBase = outCnt;
      startBase = startCnt;
      riseBase = riseCnt;
      send(tbl[s].nSym * NF, tbl[s].gap, tbl[s].rnd);
      drain();
      check({tbl[s].name, "_outputs"}, outCnt - outBase, tbl[s].expOut);
      check({tbl[s].name, "_starts"}, startCnt - startBase, tbl[s].expStarts);
      if (tbl[s].contig) begin
        check({tbl[s].name, "_contiguous"}, riseCnt - riseBase, 1);
        check({tbl[s].name, "_latency"}, riseCyc - symEndCyc, tbl[s].expLat);
      end
    end

    // Backpressure: InputEnable held high for 400 cycles.
    outBase = outCnt;
    riseBase = riseCnt;
    acc = 0;
    sawLow = 1'b0;
    needNew = 1'b1;
    bpRe = '0;
    bpIm = '0;
    for (int c = 0; c < 400; c++) begin
      @(negedge Clk);
      InputEnable = 1'b1;
      if (needNew) begin
        bpRe = DW'(acc);
        bpIm = DW'($urandom);
        needNew = 1'b0;
      end
      DataInRe = bpRe;
      DataInIm = bpIm;
      if (InputReady) begin
        model_accept(bpRe, bpIm);
        acc++;
        needNew = 1'b1;
      end else if (!sawLow) begin
        sawLow = 1'b1;
        check("ready_fall_after", acc, 128);
      end
    end
    @(negedge Clk);
    InputEnable = 1'b0;
    check("ready_fell", sawLow, 1);
    drain();
    check("bp_outputs", outCnt - outBase, (acc / NF) * (NF + NC));
    check("bp_contiguous", riseCnt - riseBase, 1);

    // Reset mid-stream at accepted sample 30 of the second symbol.
    Rst_n = 1'b0;
    repeat (2) @(negedge Clk);
    expQ.delete();
    pendQ.delete();
    Rst_n = 1'b1;
    send(NF + 30, 0, 1'b0);
    check("oe_before_reset", OutputEnable, 1);
    Rst_n = 1'b0;
    #1;
    check("rst_oe", OutputEnable, 0);
    check("rst_data", {DataOutRe, DataOutIm, SymbolStart}, 0);
    check("rst_ready", InputReady, 1);
    expQ.delete();
    pendQ.delete();
    repeat (3) @(negedge Clk);
    Rst_n = 1'b1;
    outBase = outCnt;
    send(NF, 0, 1'b1);
    drain();
    check("post_reset_outputs", outCnt - outBase, NF + NC);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cyclic_prefix_inserter.md
CYCLIC_PREFIX_INSERTER -- requirements
Module: cyclic_prefix_inserter

Interface
REQ-001 Parameter DATA_W, default 8, SHALL set the I/Q sample width: 1 sign bit, 1 integer bit, DATA_W-2 fraction bits.
REQ-002 Parameter N_FFT, default 64, SHALL set the samples per OFDM symbol body.
REQ-003 Parameter N_CP, default 16, SHALL set the cyclic prefix length; N_CP < N_FFT.
REQ-004 Clk  input  1  SHALL be the single clock; all logic samples on its rising edge.
REQ-005 Rst_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-006 InputEnable  input  1  SHALL mark a valid IFFT output sample.
REQ-007 DataInRe, DataInIm  input  DATA_W  SHALL carry the IFFT output sample.
REQ-008 InputReady  output  1  SHALL indicate the block can accept a sample this cycle.
REQ-009 OutputEnable  output  1  SHALL mark a valid transmit sample.
REQ-010 DataOutRe, DataOutIm  output  DATA_W  SHALL carry the CP-extended sample stream.
REQ-011 SymbolStart  output  1  SHALL pulse with the first CP sample of each symbol.

Function
REQ-012 A sample SHALL be accepted only on a cycle with InputEnable=1 and InputReady=1; InputEnable while InputReady=0 SHALL be ignored, with no write.
REQ-013 Storage SHALL be two banks of N_FFT entries; accepted samples SHALL be written to the write bank at index wr_idx, which increments 0..N_FFT-1.
REQ-014 On accepting index N_FFT-1, the block SHALL set full[wr_bank], wrap wr_idx to 0 and toggle wr_bank.
REQ-015 InputReady SHALL equal !full[wr_bank], decoded combinationally from registered flags.
REQ-016 Input gaps of any length SHALL be tolerated; symbol boundaries SHALL be defined only by the accepted-sample count.
REQ-017 The read FSM SHALL have states IDLE, CP and BODY.
REQ-018 In IDLE with full[rd_bank]=1, the FSM SHALL go to CP with rd_idx=N_FFT-N_CP.
REQ-019 CP SHALL read indices N_FFT-N_CP..N_FFT-1, then go to BODY with rd_idx=0.
REQ-020 BODY SHALL read indices 0..N_FFT-1; on the last read it SHALL clear full[rd_bank] and toggle rd_bank.
REQ-021 At the end of BODY, the FSM SHALL go to CP if the other bank is full, otherwise to IDLE.
REQ-022 Each symbol SHALL therefore produce exactly N_FFT+N_CP consecutive OutputEnable cycles; back-to-back symbols SHALL have zero gap cycles.
REQ-023 Latency: when the read FSM is IDLE, the first OutputEnable SHALL rise exactly 2 cycles after the clock edge that accepts sample N_FFT-1.
REQ-024 When OutputEnable=0, DataOutRe, DataOutIm and SymbolStart SHALL be 0.
REQ-025 A write completing one bank and a read releasing the other bank in the same cycle SHALL both take effect.
REQ-026 Data SHALL pass bit-exact; no arithmetic on samples.

Reset
REQ-027 Rst_n=0 SHALL immediately clear full[1:0], wr_idx, rd_idx, wr_bank and rd_bank, force state IDLE, and drive OutputEnable, SymbolStart, DataOutRe and DataOutIm to 0.
REQ-028 Reset mid-symbol SHALL discard all buffered samples; the first accepted sample after reset SHALL be index 0 of bank 0.
REQ-029 RAM contents SHALL NOT require reset.

Configuration
REQ-030 With CP_SYMBOL_CNT_EN defined, the block SHALL add output SymbolCount [15:0], reset to 0, incremented on each SymbolStart and wrapping 65535->0.
REQ-031 Without CP_SYMBOL_CNT_EN, the SymbolCount port and its counter SHALL be absent.

Structure
REQ-032 Package ofdm_tx_pkg SHALL hold DATA_W, N_FFT, N_CP and the read FSM state encoding.
REQ-033 Sub-module cp_dual_bank_ram SHALL implement the 2*N_FFT x 2*DATA_W simple dual-port RAM with a registered read.

Verification
REQ-034 Ramp: one symbol with Re=0..63, Im=63..0, contiguous -> 80 outputs Re=48..63,0..63; SymbolStart on the first output only; first output 2 cycles after the 64th accept.
REQ-035 Stream: 3 symbols, InputEnable held high -> 240 contiguous OutputEnable cycles; SymbolStart at output cycles 0, 80 and 160.
REQ-036 Backpressure: InputEnable held high for 400 cycles -> InputReady falls after 128 accepts; no sample lost or duplicated; output continuous after startup.
REQ-037 Gapped input: valid every 3rd cycle -> output is the same 80-sample sequence as the ramp case, contiguous.
REQ-038 Reset at accepted sample 30 of symbol 2 -> outputs 0 immediately; a new full symbol after reset outputs only the new data.
REQ-039 With CP_SYMBOL_CNT_EN defined: 5 symbols -> SymbolCount steps 1..5; wrap checked by forcing the counter to 65535 -> 0.
